// File: rtl/int_to_float_conv.sv
// Multi-cycle integer (IN_W = 32/64, signed or unsigned) to IEEE-754 single-precision converter.
// Define I2F_FLAGS_EN to build the inexact flag; otherwise fflags_nx is tied low.
module int_to_float_conv #(
  parameter int unsigned IN_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] input_a,
  input  logic            is_signed,
  input  logic [2:0]      rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     output_z,
  output logic            fflags_nx
);

  localparam int unsigned SC_W   = 8;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MAN_W  = FRAC_W + 1;
  localparam int unsigned LOW_W  = IN_W - MAN_W - 2;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(IN_W - 1 + 127);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t            r_state;
  logic [IN_W-1:0]   r_mag;
  logic              r_sign;
  logic [2:0]        r_rm;
  logic              r_zero;
  logic [SC_W-1:0]   r_shift;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [31:0]       r_z;

  logic              w_sign;
  logic [IN_W-1:0]   w_mag;
  logic [FRAC_W-1:0] w_frac;
  logic              w_g;
  logic              w_r;
  logic              w_s;
  logic              w_inc;
  logic [FRAC_W:0]   w_fsum;
  logic [EXP_W-1:0]  w_exp;
  logic [31:0]       w_z;

  // Operand sign and magnitude; negating the most-negative value yields 2^(IN_W-1)
  assign w_sign = is_signed & input_a[IN_W-1];
  assign w_mag  = w_sign ? (IN_W'(0) - input_a) : input_a;

  // Rounding of the normalised magnitude; the hidden bit is always 1 here
  always_comb begin
    w_frac = r_mag[IN_W-2 -: FRAC_W];
    w_g    = r_mag[IN_W-MAN_W-1];
    w_r    = r_mag[IN_W-MAN_W-2];
    w_s    = |r_mag[LOW_W-1:0];
    w_inc  = 1'b0;
    case (r_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & (w_g | w_r | w_s);
      3'b011:  w_inc = ~r_sign & (w_g | w_r | w_s);
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_r | w_s | w_frac[0]);
    endcase
    // A carry out of the fraction means 1.111..1 rounded up to 10.0
    w_fsum = {1'b0, w_frac} + (FRAC_W + 1)'(w_inc);
    w_exp  = EXP_TOP - EXP_W'(r_shift) + EXP_W'(w_fsum[FRAC_W]);
    w_z    = {r_sign, w_exp, w_fsum[FRAC_W-1:0]};
  end

`ifdef I2F_FLAGS_EN
  logic r_nx;
`endif

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_mag       <= '0;
      r_sign      <= 1'b0;
      r_rm        <= '0;
      r_zero      <= 1'b0;
      r_shift     <= '0;
`ifdef I2F_FLAGS_EN
      r_nx        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= w_sign;
            r_mag      <= w_mag;
            r_rm       <= rm;
            r_shift    <= '0;
            r_zero     <= (w_mag == '0);
            r_in_ready <= 1'b0;
            r_state    <= (w_mag == '0) ? ROUND : NORM;
          end
        end
        NORM: begin
          // Coarse byte shifts first, then single-bit steps to the leading one
          if (r_mag[IN_W-1]) begin
            r_state <= ROUND;
          end else if (r_mag[IN_W-1 -: 8] == 8'd0) begin
            r_mag   <= r_mag << 8;
            r_shift <= r_shift + SC_W'(8);
          end else begin
            r_mag   <= r_mag << 1;
            r_shift <= r_shift + SC_W'(1);
          end
        end
        ROUND: begin
          r_z         <= r_zero ? 32'd0 : w_z;
`ifdef I2F_FLAGS_EN
          r_nx        <= ~r_zero & (w_g | w_r | w_s);
`endif
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign output_z  = r_z;
`ifdef I2F_FLAGS_EN
  assign fflags_nx = r_nx;
`else
  assign fflags_nx = 1'b0;
`endif

endmodule

// File: tb/tb_int_to_float_conv.sv
// Randomised bench for int_to_float_conv (IN_W=32 and IN_W=64 instances) against a
// remainder-versus-half rounding model of integer to single-precision conversion.
module tb_int_to_float_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tb_a;
  logic        tb_sgn;
  logic [2:0]  tb_rm;
  logic        tb_ordy;
  logic        iv32, iv64;
  logic        ir32, ir64, ov32, ov64, nx32, nx64;
  logic [31:0] z32, z64;

  logic        sel64;
  logic        sel_ir, sel_ov, sel_nx;
  logic [31:0] sel_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_to_float_conv #(.IN_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .input_a(tb_a[31:0]),
    .is_signed(tb_sgn), .rm(tb_rm), .out_valid(ov32), .out_ready(tb_ordy),
    .output_z(z32), .fflags_nx(nx32)
  );

  int_to_float_conv #(.IN_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .input_a(tb_a),
    .is_signed(tb_sgn), .rm(tb_rm), .out_valid(ov64), .out_ready(tb_ordy),
    .output_z(z64), .fflags_nx(nx64)
  );

  assign sel_ir = sel64 ? ir64 : ir32;
  assign sel_ov = sel64 ? ov64 : ov32;
  assign sel_z  = sel64 ? z64  : z32;
  assign sel_nx = sel64 ? nx64 : nx32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_nx(input logic nx);
`ifdef I2F_FLAGS_EN
    return nx;
`else
    return 1'b0 & nx;
`endif
  endfunction

  // Reference: round the exact integer to 24 significant bits by comparing the
  // discarded remainder with half an ulp.
  function automatic void ref_conv(input bit w64, input logic [63:0] a, input bit sgn,
                                   input logic [2:0] mode, output logic [31:0] z,
                                   output logic nx, output bit msb);
    logic [63:0] v, mag, q, rem, half;
    bit neg, up;
    int width, p;
    width = w64 ? 64 : 32;
    v     = w64 ? a : {32'd0, a[31:0]};
    neg   = sgn && v[width-1];
    if (neg) mag = w64 ? (64'd0 - v) : (64'h1_0000_0000 - v);
    else     mag = v;
    z = 32'd0; nx = 1'b0; msb = 1'b0;
    if (mag == 64'd0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    msb = (p == width - 1);
    rem = 64'd0; half = 64'd0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      q    = mag >> (p - 23);
      rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
    end
    up = 1'b0;
    if (rem != 64'd0) begin
      case (mode)
        3'd1:    up = 1'b0;
        3'd2:    up = neg;
        3'd3:    up = !neg;
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
    end
    q = q + 64'(up);
    if (q[24]) begin
      q = q >> 1;
      p = p + 1;
    end
    z  = {neg, 8'(p + 127), q[22:0]};
    nx = (rem != 64'd0);
  endfunction

  // Drive one operand through the chosen DUT and collect its result and latency
  task automatic run_op(input bit w64, input logic [63:0] a, input bit sgn,
                        input logic [2:0] mode, input int hold,
                        output logic [31:0] z, output logic nx, output int lat);
    int n;
    sel64 = w64;
    #0;
    n = 0;
    while (!sel_ir && n < 40) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_op", sel_ir, 1);
    tb_a = a; tb_sgn = sgn; tb_rm = mode;
    iv32 = !w64; iv64 = w64;
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    tb_a = {$urandom, $urandom}; tb_sgn = 1'($urandom); tb_rm = 3'($urandom);
    lat = 1;
    while (!sel_ov && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_seen", sel_ov, 1);
    chk("in_ready_while_valid", sel_ir, 0);
    z  = sel_z;
    nx = sel_nx;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_z_stable", sel_z, z);
      chk("hold_out_valid", sel_ov, 1);
      chk("hold_in_ready", sel_ir, 0);
    end
    tb_ordy = 1'b1;
    @(posedge clk); #1;
    tb_ordy = 1'b0;
    chk("in_ready_after_take", sel_ir, 1);
    chk("out_valid_after_take", sel_ov, 0);
  endtask

  task automatic do_test(input bit w64, input logic [63:0] a, input bit sgn,
                         input logic [2:0] mode, input int hold, input bit use_const,
                         input logic [31:0] want_z, input logic want_nx);
    logic [31:0] z, rz;
    logic nx, rnx;
    bit msb;
    int lat;
    run_op(w64, a, sgn, mode, hold, z, nx, lat);
    ref_conv(w64, a, sgn, mode, rz, rnx, msb);
    chk($sformatf("z w64=%0d a=%h s=%0d rm=%0d", w64, a, sgn, mode), 64'(z), 64'(rz));
    chk($sformatf("nx w64=%0d a=%h s=%0d rm=%0d", w64, a, sgn, mode), 64'(nx), 64'(exp_nx(rnx)));
    if (use_const) begin
      chk($sformatf("z_vector a=%h rm=%0d", a, mode), 64'(z), 64'(want_z));
      chk($sformatf("nx_vector a=%h rm=%0d", a, mode), 64'(nx), 64'(exp_nx(want_nx)));
    end
    chk($sformatf("latency_max a=%h", a), 64'(lat <= (w64 ? 18 : 14)), 64'd1);
    if (msb) chk($sformatf("latency_msb a=%h", a), 64'(lat), 64'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int bad;
    rst = 1'b0; sel64 = 1'b0; tb_a = '0; tb_sgn = 1'b0; tb_rm = '0;
    tb_ordy = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ov32, 0);
    chk("rst_in_ready", ir32, 1);
    chk("rst_output_z", z32, 0);
    chk("rst_nx", nx32, 0);
    chk("rst_out_valid64", ov64, 0);
    chk("rst_in_ready64", ir64, 1);
    rst = 1'b1;

    // Known vectors
    do_test(0, 64'h0000_0001, 0, 3'd0, 0, 1, 32'h3F80_0000, 1'b0);
    do_test(0, 64'hFFFF_FFFF, 1, 3'd0, 0, 1, 32'hBF80_0000, 1'b0);
    do_test(0, 64'hFFFF_FFFF, 0, 3'd0, 0, 1, 32'h4F80_0000, 1'b1);
    do_test(0, 64'hFFFF_FFFF, 0, 3'd1, 0, 1, 32'h4F7F_FFFF, 1'b1);
    do_test(0, 64'h0100_0001, 0, 3'd0, 0, 1, 32'h4B80_0000, 1'b1);
    do_test(0, 64'h0100_0001, 0, 3'd3, 0, 1, 32'h4B80_0001, 1'b1);
    do_test(0, 64'h8000_0000, 1, 3'd0, 0, 1, 32'hCF00_0000, 1'b0);
    do_test(0, 64'h0000_0000, 0, 3'd0, 0, 1, 32'h0000_0000, 1'b0);
    do_test(1, 64'h8000_0000_0000_0000, 0, 3'd0, 0, 1, 32'h5F00_0000, 1'b0);
    do_test(1, 64'h0000_0000_0000_0001, 0, 3'd0, 0, 1, 32'h3F80_0000, 1'b0);
    do_test(1, 64'h8000_0000_0000_0000, 1, 3'd0, 0, 1, 32'hDF00_0000, 1'b0);
    // Backpressure on a result
    do_test(0, 64'h1234_5678, 0, 3'd2, 5, 0, 32'h0, 1'b0);

    // Reset in the middle of normalisation
    sel64 = 1'b0;
    tb_a = 64'h1; tb_sgn = 1'b0; tb_rm = 3'd0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_out_valid", ov32, 0);
    chk("midrst_in_ready", ir32, 1);
    chk("midrst_output_z", z32, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov32) bad++;
    end
    chk("midrst_no_stale_result", 64'(bad), 64'd0);
    do_test(0, 64'hFFFF_FF85, 1, 3'd4, 0, 0, 32'h0, 1'b0);

    // Random operands over both widths, with magnitudes spread across exponents
    for (int i = 0; i < 200; i++) begin
      a = {32'd0, $urandom} >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = {32'd0, 1'b1, 31'($urandom)};
      do_test(0, a, 1'($urandom), 3'($urandom), $urandom_range(0, 2), 0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 80; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = {1'b1, 63'({$urandom, $urandom})};
      do_test(1, a, 1'($urandom), 3'($urandom), $urandom_range(0, 1), 0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_to_float_conv.md
INT_TO_FLOAT_CONV -- requirements
Module: int_to_float_conv

Interface
REQ-001 SHALL have parameter IN_W, default 32; integer operand width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand present.
REQ-005 SHALL have port in_ready  output  1  converter idle, can accept operand.
REQ-006 SHALL have port input_a  input  IN_W  integer operand.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement operand, 0 = unsigned.
REQ-008 SHALL have port rm  input  3  RISC-V rounding mode.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port output_z  output  32  IEEE-754 single-precision result.
REQ-012 SHALL have port fflags_nx  output  1  inexact flag for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_ready and out_valid SHALL never both be 1.
REQ-015 SHALL accept an operand when in_valid&&in_ready, latching input_a, is_signed and rm; later changes on those inputs SHALL be ignored until the next acceptance.
REQ-016 On acceptance, SHALL set sign = is_signed & input_a[IN_W-1] and magnitude = the two's-complement negation of input_a when sign=1, else input_a; for the most-negative signed value the magnitude SHALL be 2^(IN_W-1).
REQ-017 A zero operand SHALL go IDLE->ROUND directly and produce output_z=0x00000000 with fflags_nx=0.
REQ-018 NORM, per cycle: if the magnitude MSB is set, go to ROUND; else if the top 8 bits are zero, shift left 8 and add 8 to shift count; else shift left 1 and add 1.
REQ-019 Unbiased exponent SHALL be IN_W-1-shift_count; mantissa = bits [IN_W-1:IN_W-24]; guard = next bit; round = following bit; sticky = OR of all remaining lower bits.
REQ-020 ROUND SHALL apply rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; codes 101-111 SHALL be treated as RNE. RDN/RUP direction SHALL depend on sign.
REQ-021 A mantissa carry-out from rounding SHALL increment the exponent and reset the mantissa to 1.0; exponent overflow cannot occur for IN_W<=64 and needs no handling.
REQ-022 Packed result = {sign, exponent+127, mantissa[22:0]}; fflags_nx = guard|round|sticky.
REQ-023 DONE SHALL assert out_valid with output_z/fflags_nx stable until out_valid&&out_ready, then go to IDLE in the next cycle.
REQ-024 Latency SHALL be 3 cycles from acceptance to out_valid when the operand MSB is set after negation, and at most IN_W/8+10 cycles for any operand.

Reset
REQ-025 When rst=0 at a clock edge, the FSM SHALL enter IDLE, with out_valid=0, in_ready=1 on the next cycle, output_z=0 and fflags_nx=0, aborting any conversion in flight.
REQ-026 A result aborted by reset SHALL never be presented.

Configuration
REQ-027 With macro I2F_FLAGS_EN defined, fflags_nx SHALL follow REQ-022; without it, fflags_nx SHALL be constant 0 and the inexact logic SHALL be omitted. Rounding SHALL be unaffected either way.

Verification
REQ-028 IN_W=32, unsigned 0x00000001, rm=000 -> 0x3F800000, nx=0; signed 0xFFFFFFFF -> 0xBF800000, nx=0.
REQ-029 Unsigned 0xFFFFFFFF: rm=000 -> 0x4F800000, nx=1; rm=001 -> 0x4F7FFFFF, nx=1.
REQ-030 Unsigned 0x01000001: rm=000 -> 0x4B800000, nx=1; rm=011 -> 0x4B800001; signed 0x80000000 -> 0xCF000000, nx=0, out_valid exactly 3 cycles after acceptance.
REQ-031 Operand 0 -> 0x00000000, nx=0; IN_W=64, unsigned 0x8000000000000000 -> 0x5F000000.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles -> output_z stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 in the following cycle.
REQ-033 Reset mid-NORM: rst=0 for one cycle -> out_valid stays 0 and in_ready=1 in the next cycle; a new operand then converts correctly.
